// File: rtl/instr_mem_dp.sv
// instr_mem_dp
//   Synchronous dual-port instruction/data memory.
//   Fetch port (if_*): word-aligned reads for the IF stage, with stall hold
//   and misaligned/out-of-range error reporting.
//   Load/store port (ls_*): word reads and byte-enabled writes for the LSU.
//   A write returns the merged post-write word.
//   Both ports respond one cycle after the request with a valid strobe.
//   A fetch of the word being written in the same cycle sees the new data.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   if_req/if_addr    : fetch request and byte address
//   if_stall          : hold fetch outputs, drop fetch requests
//   if_rdata/valid/err: fetch response
//   ls_req/we/be      : LSU request, write select, byte enables
//   ls_addr/ls_wdata  : LSU byte address and lane-aligned write data
//   ls_rdata/valid/err: LSU response (read data or post-write word)
module instr_mem_dp #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter string       INIT_PLUSARG = "mem_init"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_stall,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_valid,
  output logic                ls_err
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(NB);
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Address decode
  logic [ADDR_W-1:0] if_idx, ls_idx;
  logic [MEM_AW-1:0] if_widx, ls_widx;
  logic              if_in_range, ls_in_range, if_misaligned;

  assign if_idx        = if_addr >> OFF_W;
  assign ls_idx        = ls_addr >> OFF_W;
  assign if_widx       = if_idx[MEM_AW-1:0];
  assign ls_widx       = ls_idx[MEM_AW-1:0];
  assign if_in_range   = 64'(if_idx) < 64'(DEPTH);
  assign ls_in_range   = 64'(ls_idx) < 64'(DEPTH);
  assign if_misaligned = (if_addr & ADDR_W'(NB - 1)) != '0;

  // Byte-lane merge of the LSU write into the currently stored word
  logic [DATA_W-1:0] ls_cur, ls_merged;
  logic              ls_wr_en;

  always_comb begin
    ls_cur    = mem[ls_widx];
    ls_merged = ls_cur;
    for (int unsigned b = 0; b < NB; b++) begin
      if (ls_be[b]) ls_merged[b*8 +: 8] = ls_wdata[b*8 +: 8];
    end
  end

  assign ls_wr_en = ls_req && ls_we && ls_in_range && !rst;

  always_ff @(posedge clk) begin
    if (ls_wr_en) mem[ls_widx] <= ls_merged;
  end

  // Response registers
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              if_valid_q, if_valid_d, if_err_q, if_err_d;
  logic              ls_valid_q, ls_valid_d, ls_err_q, ls_err_d;

  always_comb begin
    if_rdata_d = if_rdata_q;
    if_valid_d = if_valid_q;
    if_err_d   = if_err_q;
    if (!if_stall) begin
      if_valid_d = if_req;
      if_err_d   = 1'b0;
      if (if_req) begin
        if (if_misaligned || !if_in_range) begin
          if_err_d   = 1'b1;
          if_rdata_d = '0;
        end else if (ls_wr_en && (ls_widx == if_widx)) begin
          // Same-cycle write to the fetched word: forward the merged data
          if_rdata_d = ls_merged;
        end else begin
          if_rdata_d = mem[if_widx];
        end
      end
    end
  end

  always_comb begin
    ls_rdata_d = ls_rdata_q;
    ls_valid_d = ls_req;
    ls_err_d   = 1'b0;
    if (ls_req) begin
      if (!ls_in_range) begin
        ls_err_d   = 1'b1;
        ls_rdata_d = '0;
      end else begin
        ls_rdata_d = ls_we ? ls_merged : ls_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      ls_rdata_q <= '0;
      ls_valid_q <= 1'b0;
      ls_err_q   <= 1'b0;
    end else begin
      if_rdata_q <= if_rdata_d;
      if_valid_q <= if_valid_d;
      if_err_q   <= if_err_d;
      ls_rdata_q <= ls_rdata_d;
      ls_valid_q <= ls_valid_d;
      ls_err_q   <= ls_err_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign if_err   = if_err_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_valid = ls_valid_q;
  assign ls_err   = ls_err_q;

endmodule

// File: tb/tb_instr_mem_dp.sv
// Testbench for instr_mem_dp: directed scenarios plus randomized traffic,
// checked against a word/byte-level reference model of the memory.
module tb_instr_mem_dp;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_stall;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_err;
  logic        ls_req, ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_valid, ls_err;

  always #5 clk = ~clk;

  instr_mem_dp #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .ls_err(ls_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: word contents plus per-byte "known" flags
  logic [31:0] mem_m [DEPTH];
  logic [3:0]  kn_m  [DEPTH];

  logic [31:0] e_if_data, e_ls_data;
  logic [3:0]  e_if_mask, e_ls_mask;
  logic        e_if_valid, e_if_err, e_ls_valid, e_ls_err;

  function automatic logic [31:0] bmask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic clear_exp();
    e_if_data = '0; e_if_mask = '1; e_if_valid = 1'b0; e_if_err = 1'b0;
    e_ls_data = '0; e_ls_mask = '1; e_ls_valid = 1'b0; e_ls_err = 1'b0;
  endtask

  // One clock of traffic using the current input values
  task automatic cycle();
    int unsigned li, ii;
    bit          lin, lwr;
    logic [31:0] cur, merged;
    logic [3:0]  cmask, mmask;
    li  = ls_addr / 4;
    lin = (li < DEPTH);
    cur = '0; cmask = '0;
    if (lin) begin cur = mem_m[li]; cmask = kn_m[li]; end
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = ls_be[b] ? ls_wdata[b*8 +: 8] : cur[b*8 +: 8];
      mmask[b]         = ls_be[b] ? 1'b1 : cmask[b];
    end
    lwr = ls_req && ls_we && lin && !rst;
    if (rst) begin
      clear_exp();
    end else begin
      e_ls_valid = ls_req;
      e_ls_err   = 1'b0;
      if (ls_req) begin
        if (!lin) begin
          e_ls_err = 1'b1; e_ls_data = '0; e_ls_mask = '1;
        end else if (ls_we) begin
          e_ls_data = merged; e_ls_mask = mmask;
        end else begin
          e_ls_data = cur; e_ls_mask = cmask;
        end
      end
      if (!if_stall) begin
        e_if_valid = if_req;
        e_if_err   = 1'b0;
        if (if_req) begin
          ii = if_addr / 4;
          if ((if_addr % 4) != 0 || ii >= DEPTH) begin
            e_if_err = 1'b1; e_if_data = '0; e_if_mask = '1;
          end else if (lwr && li == ii) begin
            e_if_data = merged; e_if_mask = mmask;
          end else begin
            e_if_data = mem_m[ii]; e_if_mask = kn_m[ii];
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (lwr) begin mem_m[li] = merged; kn_m[li] = mmask; end
    check("if_valid", {31'b0, if_valid}, {31'b0, e_if_valid});
    if (e_if_valid) begin
      check("if_err", {31'b0, if_err}, {31'b0, e_if_err});
      check("if_rdata", if_rdata & bmask(e_if_mask), e_if_data & bmask(e_if_mask));
    end
    check("ls_valid", {31'b0, ls_valid}, {31'b0, e_ls_valid});
    if (e_ls_valid) begin
      check("ls_err", {31'b0, ls_err}, {31'b0, e_ls_err});
      check("ls_rdata", ls_rdata & bmask(e_ls_mask), e_ls_data & bmask(e_ls_mask));
    end
  endtask

  task automatic idle();
    if_req = 1'b0; if_stall = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_be = '0;
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = d; ls_be = be;
    cycle();
    ls_req = 1'b0; ls_we = 1'b0;
  endtask

  task automatic lsu_read(input logic [31:0] a);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = a;
    cycle();
    ls_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    cycle();
    if_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
    check({tag, "_if_err"},   {31'b0, if_err},   32'h0);
    check({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    check({tag, "_ls_valid"}, {31'b0, ls_valid}, 32'h0);
    check({tag, "_ls_err"},   {31'b0, ls_err},   32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    case ($urandom_range(0, 9))
      0:       w = DEPTH - 1;
      1:       w = DEPTH + $urandom_range(0, 100);
      default: w = $urandom_range(0, 31);
    endcase
    w = w * 4;
    if ($urandom_range(0, 7) == 0) w = w | $urandom_range(1, 3);
    return w;
  endfunction

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin mem_m[i] = '0; kn_m[i] = '0; end
    clear_exp();
    idle();
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Preload
    lsu_write(32'h10,  32'hDEADBEEF, 4'hF);
    lsu_write(32'h14,  32'h00000013, 4'hF);
    lsu_write(32'h08,  32'h11223344, 4'hF);
    lsu_write(32'h40,  32'h01020304, 4'hF);
    lsu_write(32'h44,  32'h55667788, 4'hF);
    lsu_write(32'h00,  32'hA5A5A5A5, 4'hF);
    lsu_write(32'hFFC, 32'h5A5A5A5A, 4'hF);

    // Fetch stream, back to back, then misaligned
    if_req = 1'b1; if_addr = 32'h10; cycle();
    check("fetch_10", if_rdata, 32'hDEADBEEF);
    if_addr = 32'h14; cycle();
    check("fetch_14", if_rdata, 32'h00000013);
    check("fetch_14_valid", {31'b0, if_valid}, 32'h1);
    if_addr = 32'h12; cycle();
    check("fetch_mis_err", {31'b0, if_err}, 32'h1);
    check("fetch_mis_data", if_rdata, 32'h0);
    if_req = 1'b0;

    // Byte-enable write
    lsu_write(32'h08, 32'hAABBCCDD, 4'b0101);
    check("be_merge", ls_rdata, 32'h11BB33DD);
    lsu_read(32'h08);
    check("be_readback", ls_rdata, 32'h11BB33DD);
    lsu_write(32'h08, 32'hFFFFFFFF, 4'b0000);
    check("be_zero", ls_rdata, 32'h11BB33DD);

    // Write-first collision and non-colliding word
    if_req = 1'b1; if_addr = 32'h40;
    lsu_write(32'h40, 32'hCAFEF00D, 4'hF);
    check("wf_same", if_rdata, 32'hCAFEF00D);
    if_addr = 32'h44;
    lsu_write(32'h40, 32'h0BADC0DE, 4'hF);
    check("wf_other", if_rdata, 32'h55667788);
    if_req = 1'b0;

    // Range
    fetch(32'h1000);
    check("range_fetch_err", {31'b0, if_err}, 32'h1);
    lsu_write(32'h1000, 32'h12345678, 4'hF);
    check("range_ls_err", {31'b0, ls_err}, 32'h1);
    check("range_ls_data", ls_rdata, 32'h0);
    lsu_read(32'h0);
    check("range_word0", ls_rdata, 32'hA5A5A5A5);
    lsu_read(32'hFFC);
    check("range_word1023", ls_rdata, 32'h5A5A5A5A);

    // Stall hold, dropped request, release
    fetch(32'h10);
    if_stall = 1'b1; if_req = 1'b1; if_addr = 32'h14;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold", if_rdata, 32'hDEADBEEF);
      check("stall_valid", {31'b0, if_valid}, 32'h1);
    end
    if_stall = 1'b0;
    cycle();
    check("stall_release", if_rdata, 32'h00000013);
    if_req = 1'b0;

    // Asynchronous reset mid-cycle with both ports busy
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h14;
    cycle();
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    clear_exp();
    ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'h0; ls_be = 4'hF;
    cycle();
    rst = 1'b0;
    idle();
    cycle();
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_addr = 32'h10;
    cycle();
    check("post_rst_fetch", if_rdata, 32'hDEADBEEF);
    check("post_rst_ls", ls_rdata, 32'hDEADBEEF);
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if_req   = ($urandom_range(0, 3) != 0);
      if_stall = ($urandom_range(0, 4) == 0);
      if_addr  = rand_addr();
      ls_req   = $urandom_range(0, 1) == 1;
      ls_we    = $urandom_range(0, 1) == 1;
      ls_be    = 4'($urandom);
      ls_addr  = rand_addr();
      ls_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) ls_addr = if_addr & 32'hFFFF_FFFC;
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
